// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// FETCH_SQUASH_EN selects wrong-path squashing over an architectural delay slot.
package fetch_pkg;

    localparam int INSN_W = 32;
    localparam int ADDR_W = 64;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h910003FF;

    localparam int IMM26_LSB = 0;
    localparam int IMM26_MSB = 25;
    localparam int IMM19_LSB = 5;
    localparam int IMM19_MSB = 23;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC = '0;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc4;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus between fetch and a combinational instruction memory.
interface fetch_if
    import fetch_pkg::*;
();

    logic [ADDR_W-1:0] imem_addr;
    logic [INSN_W-1:0] imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);

endinterface

// File: rtl/fetch_stage_branch_target.sv
// Decode-stage branch target: PC-relative (imm26/imm19) or register (BR).
module branch_target
    import fetch_pkg::*;
(
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [INSN_W-1:0] instruction,
    input  logic              uncond_br,
    input  logic              br_reg,
    input  logic [ADDR_W-1:0] br_reg_val,
    output logic [ADDR_W-1:0] target
);

    localparam int IMM26_W = IMM26_MSB - IMM26_LSB + 1;
    localparam int IMM19_W = IMM19_MSB - IMM19_LSB + 1;

    logic [ADDR_W-1:0] offset;
    logic              unused_bits;

    assign unused_bits = ^{instruction[INSN_W-1:IMM26_MSB+1], br_reg_val[1:0]};

    always_comb begin
        offset = '0;
        if (uncond_br)
            offset = {{(ADDR_W-IMM26_W){instruction[IMM26_MSB]}},
                      instruction[IMM26_MSB:IMM26_LSB]};
        else
            offset = {{(ADDR_W-IMM19_W){instruction[IMM19_MSB]}},
                      instruction[IMM19_MSB:IMM19_LSB]};

        target = id_pc + (offset << 2);
        // Register targets drop the low bits silently.
        if (br_reg)
            target = {br_reg_val[ADDR_W-1:2], 2'b00};
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register, imem addressing and IF/ID pipeline register.
// FETCH_SQUASH_EN: replace the taken-branch slot with a NOP bubble.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic              uncond_br,
    input  logic              br_reg,
    input  logic [ADDR_W-1:0] br_reg_val,
    fetch_if.master           imem,
    output logic [INSN_W-1:0] instruction,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] PCReg,
    output logic              id_valid
);

    localparam if_id_t IFID_RST = '{
        insn:  NOP_INSN,
        pc:    '0,
        pc4:   64'd4,
        valid: 1'b0
    };

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] target;
    if_id_t            ifid_q;
    if_id_t            ifid_d;
    logic              br_eff;

    assign br_eff = br_taken & ifid_q.valid & ~stall;

    branch_target u_target (
        .id_pc       (ifid_q.pc),
        .instruction (ifid_q.insn),
        .uncond_br   (uncond_br),
        .br_reg      (br_reg),
        .br_reg_val  (br_reg_val),
        .target      (target)
    );

    always_comb begin
        pc_d   = pc_q + 64'd4;
        ifid_d = '{
            insn:  imem.imem_data,
            pc:    pc_q,
            pc4:   pc_q + 64'd4,
            valid: 1'b1
        };
        if (stall) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
        end else if (br_eff) begin
            pc_d = target;
`ifdef FETCH_SQUASH_EN
            ifid_d.insn  = NOP_INSN;
            ifid_d.valid = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            ifid_q <= IFID_RST;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign instruction    = ifid_q.insn;
    assign id_pc          = ifid_q.pc;
    assign PCReg          = ifid_q.pc4;
    assign id_valid       = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage.
// Memory returns 32'hAAAA0000 + addr except at a few branch locations.
module tb_fetch_stage;

    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic        uncond_br;
    logic        br_reg;
    logic [63:0] br_reg_val;
    logic [31:0] instruction;
    logic [63:0] id_pc;
    logic [63:0] PCReg;
    logic        id_valid;

    int n_vec = 0;
    int n_err = 0;

    fetch_if bus ();

    fetch_stage #(.RESET_PC(64'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .uncond_br   (uncond_br),
        .br_reg      (br_reg),
        .br_reg_val  (br_reg_val),
        .imem        (bus),
        .instruction (instruction),
        .id_pc       (id_pc),
        .PCReg       (PCReg),
        .id_valid    (id_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (bus.imem_addr)
            64'h20:  bus.imem_data = 32'hD61F0000;
            64'h40:  bus.imem_data = 32'h17FFFFFE;
            64'h100: bus.imem_data = 32'hB4000060;
            default: bus.imem_data = 32'hAAAA0000 + bus.imem_addr[31:0];
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_br();
        br_taken   = 1'b0;
        uncond_br  = 1'b0;
        br_reg     = 1'b0;
        br_reg_val = '0;
    endtask

    task automatic run_to(input logic [63:0] pc);
        for (int i = 0; i < 64; i++) begin
            if (id_valid && id_pc == pc) break;
            tick();
        end
        chk("reach_pc", id_pc, pc);
    endtask

    task automatic br_to(input logic [63:0] dst);
        br_taken   = 1'b1;
        br_reg     = 1'b1;
        br_reg_val = dst;
        tick();
        clr_br();
    endtask

    task automatic chk_slot(input logic [63:0] pc);
`ifdef FETCH_SQUASH_EN
        chk("slot_insn", {32'd0, instruction}, {32'd0, NOP_INSN});
        chk("slot_vld", {63'd0, id_valid}, 64'd0);
`else
        logic [31:0] w;
        w = 32'hAAAA0000 + pc[31:0];
        chk("slot_insn", {32'd0, instruction}, {32'd0, w});
        chk("slot_vld", {63'd0, id_valid}, 64'd1);
`endif
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        clr_br();
        tick();
        tick();
        chk("rst_addr", bus.imem_addr, 64'h0);
        chk("rst_insn", {32'd0, instruction}, 64'h910003FF);
        chk("rst_idpc", id_pc, 64'h0);
        chk("rst_pcreg", PCReg, 64'h4);
        chk("rst_vld", {63'd0, id_valid}, 64'd0);

        // Boot: branch request on the reset bubble must be ignored.
        reset      = 1'b1;
        br_taken   = 1'b1;
        br_reg     = 1'b1;
        br_reg_val = 64'h500;
        tick();
        clr_br();
        chk("boot_addr", bus.imem_addr, 64'h4);
        chk("boot_vld", {63'd0, id_valid}, 64'd1);
        chk("boot_insn", {32'd0, instruction}, 64'hAAAA0000);
        chk("boot_idpc", id_pc, 64'h0);
        chk("boot_pcreg", PCReg, 64'h4);
        tick();
        chk("seq_addr", bus.imem_addr, 64'h8);
        chk("seq_insn", {32'd0, instruction}, 64'hAAAA0004);

        // BR with misaligned register value.
        run_to(64'h20);
        br_to(64'h203);
        chk("br_addr", bus.imem_addr, 64'h200);
        chk_slot(64'h24);

        run_to(64'h200);
        br_to(64'h40);

        // B imm26 = -2 at 0x40.
        run_to(64'h40);
        chk("b_insn", {32'd0, instruction}, 64'h17FFFFFE);
        br_taken  = 1'b1;
        uncond_br = 1'b1;
        tick();
        clr_br();
        chk("b_addr", bus.imem_addr, 64'h38);
        chk_slot(64'h44);

        run_to(64'h38);
        br_to(64'h100);

        // CBZ imm19 = 3 at 0x100.
        run_to(64'h100);
        br_taken = 1'b1;
        tick();
        clr_br();
        chk("cbz_addr", bus.imem_addr, 64'h10C);

        run_to(64'h10C);
        br_to(64'h10);

        // Stall held two cycles with a pending branch.
        run_to(64'h10);
        stall      = 1'b1;
        br_taken   = 1'b1;
        br_reg     = 1'b1;
        br_reg_val = 64'h300;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stl_addr", bus.imem_addr, 64'h14);
            chk("stl_insn", {32'd0, instruction}, 64'hAAAA0010);
            chk("stl_idpc", id_pc, 64'h10);
            chk("stl_pcreg", PCReg, 64'h14);
            chk("stl_vld", {63'd0, id_valid}, 64'd1);
        end
        stall = 1'b0;
        tick();
        clr_br();
        chk("stl_redir", bus.imem_addr, 64'h300);

        // PC wrap at the top of the address space.
        run_to(64'h300);
        br_to(64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_tgt", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_addr", bus.imem_addr, 64'h0);
        chk("wrap_idpc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pcreg", PCReg, 64'h0);

        // Reset beats a taken branch.
        tick();
        br_taken   = 1'b1;
        br_reg     = 1'b1;
        br_reg_val = 64'h700;
        reset      = 1'b0;
        tick();
        clr_br();
        chk("mrst_addr", bus.imem_addr, 64'h0);
        chk("mrst_insn", {32'd0, instruction}, 64'h910003FF);
        chk("mrst_vld", {63'd0, id_valid}, 64'd0);
        chk("mrst_idpc", id_pc, 64'h0);
        chk("mrst_pcreg", PCReg, 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
